// File: rtl/add_sub_pipe.sv
// Two-stage pipelined signed adder/subtractor with valid/ready flow control,
// optional saturation, comparison flags and a saturating overflow event counter.
module add_sub_pipe #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [4:0]       ctrl_ALUopcode,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             overflow,
    output logic             isNotEqual,
    output logic             isLessThan,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             ovf_clear
);

    localparam int H = WIDTH / 2;

    logic         adv1;
    logic         adv2;
    logic         s1_valid;
    logic [H-1:0] s1_lo_sum;
    logic         s1_lo_carry;
    logic [H-1:0] s1_a_hi;
    logic [H-1:0] s1_b_hi;
    logic         s1_sub;
    logic         s1_sat;
    logic         s1_neq;

    logic         op_sub;
    logic [H-1:0] b_lo_eff;
    logic [H:0]   lo_sum;

    logic [H-1:0]     b_hi_eff;
    logic [H-1:0]     hi_low_sum;
    logic             carry_into_msb;
    logic             carry_out_msb;
    logic             msb_sum;
    logic             ovf_calc;
    logic [WIDTH-1:0] raw_result;
    logic [WIDTH-1:0] final_result;

    // Stage 2 drains when the consumer takes its result or when it is empty;
    // stage 1 can then always move forward, so an empty stage 1 keeps filling.
    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;

    // Subtraction is A + ~B + 1: the inversion and carry-in are applied per half.
    assign op_sub   = ctrl_ALUopcode[0];
    assign b_lo_eff = op_sub ? ~data_operandB[H-1:0] : data_operandB[H-1:0];
    assign lo_sum   = {1'b0, data_operandA[H-1:0]} + {1'b0, b_lo_eff} + {{H{1'b0}}, op_sub};

    assign b_hi_eff       = s1_sub ? ~s1_b_hi : s1_b_hi;
    assign hi_low_sum     = {1'b0, s1_a_hi[H-2:0]} + {1'b0, b_hi_eff[H-2:0]} + {{(H-1){1'b0}}, s1_lo_carry};
    assign carry_into_msb = hi_low_sum[H-1];
    assign msb_sum        = s1_a_hi[H-1] ^ b_hi_eff[H-1] ^ carry_into_msb;
    assign carry_out_msb  = (s1_a_hi[H-1] & b_hi_eff[H-1]) |
                            (s1_a_hi[H-1] & carry_into_msb) |
                            (b_hi_eff[H-1] & carry_into_msb);
    assign ovf_calc       = carry_into_msb ^ carry_out_msb;
    assign raw_result     = {msb_sum, hi_low_sum[H-2:0], s1_lo_sum};

    // On overflow the true result has the sign of A, which picks the clamp rail.
    always_comb begin
        final_result = raw_result;
        if (s1_sat && ovf_calc) begin
            final_result = s1_a_hi[H-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid    <= 1'b0;
            s1_lo_sum   <= '0;
            s1_lo_carry <= 1'b0;
            s1_a_hi     <= '0;
            s1_b_hi     <= '0;
            s1_sub      <= 1'b0;
            s1_sat      <= 1'b0;
            s1_neq      <= 1'b0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_lo_sum   <= lo_sum[H-1:0];
                s1_lo_carry <= lo_sum[H];
                s1_a_hi     <= data_operandA[WIDTH-1:H];
                s1_b_hi     <= data_operandB[WIDTH-1:H];
                s1_sub      <= op_sub;
                s1_sat      <= sat_en;
                s1_neq      <= (data_operandA != data_operandB);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            data_result <= '0;
            overflow    <= 1'b0;
            isNotEqual  <= 1'b0;
            isLessThan  <= 1'b0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                data_result <= final_result;
                overflow    <= ovf_calc;
                isNotEqual  <= s1_neq;
                isLessThan  <= msb_sum ^ ovf_calc;
            end
        end
    end

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf_count <= '0;
        end else if (ovf_clear) begin
            ovf_count <= '0;
        end else if (out_valid && out_ready && overflow && (ovf_count != {CNT_W{1'b1}})) begin
            ovf_count <= ovf_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_add_sub_pipe.sv
// Scoreboard bench for add_sub_pipe: a driver queues expected results computed
// with plain integer arithmetic, and a monitor checks every delivered result.
module tb_add_sub_pipe;

    localparam int WIDTH = 32;
    localparam int CNT_W = 8;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             ovf;
        logic             neq;
        logic             lt;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [4:0]       ctrl_ALUopcode;
    logic             sat_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_result;
    logic             overflow;
    logic             isNotEqual;
    logic             isLessThan;
    logic [CNT_W-1:0] ovf_count;
    logic             ovf_clear;

    int   test_count  = 0;
    int   error_count = 0;
    exp_t exp_q[$];

    add_sub_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .ctrl_ALUopcode(ctrl_ALUopcode), .sat_en(sat_en), .out_valid(out_valid),
        .out_ready(out_ready), .data_result(data_result), .overflow(overflow),
        .isNotEqual(isNotEqual), .isLessThan(isLessThan), .ovf_count(ovf_count),
        .ovf_clear(ovf_clear)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        test_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // True mathematical sum/difference in 64 bits, then judged against the 32-bit range.
    function automatic exp_t refModel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                      input logic [4:0] op, input logic sat);
        exp_t   e;
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint max_v = (longint'(1) <<< 31) - 1;
        longint min_v = -(longint'(1) <<< 31);
        longint r = op[0] ? (sa - sb) : (sa + sb);
        e.ovf = (r > max_v) || (r < min_v);
        e.neq = (a != b);
        e.lt  = (r < 0);
        e.res = r[WIDTH-1:0];
        if (e.ovf && sat) e.res = a[WIDTH-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return e;
    endfunction

    function automatic exp_t mkExp(input logic [WIDTH-1:0] res, input logic ovf, input logic neq, input logic lt);
        exp_t e;
        e.res = res; e.ovf = ovf; e.neq = neq; e.lt = lt;
        return e;
    endfunction

    // Presents one operand set until accepted; returns on the accepting edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [4:0] op, input logic sat, input exp_t e,
                                 input bit rand_ready);
        bit acc = 0;
        int tries = 0;
        while (!acc && tries < 100) begin
            @(negedge clock);
            in_valid = 1'b1;
            data_operandA = a;
            data_operandB = b;
            ctrl_ALUopcode = op;
            sat_en = sat;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc = in_ready;
            if (acc) exp_q.push_back(e);
            @(posedge clock);
            tries++;
        end
        if (!acc) checkOutput("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clock);
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) checkOutput("drain_timeout", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clock);
    endtask

    // Monitor: pops on every transfer, tracks the counter, checks stall stability.
    initial begin
        int          model_cnt = 0;
        int          next_cnt;
        bit          hold_pend = 0;
        logic [35:0] saved = '0;
        exp_t        e;
        forever begin
            @(negedge clock);
            #1;
            if (!reset_n) begin
                exp_q.delete();
                model_cnt = 0;
                hold_pend = 0;
                continue;
            end
            checkOutput("ovf_count", 64'(ovf_count), 64'(model_cnt));
            if (hold_pend)
                checkOutput("stall_hold", 64'({out_valid, data_result, overflow, isNotEqual, isLessThan}), 64'(saved));
            hold_pend = out_valid && !out_ready;
            saved = {out_valid, data_result, overflow, isNotEqual, isLessThan};
            next_cnt = model_cnt;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_result", 64'(data_result), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("result", {29'd0, data_result, overflow, isNotEqual, isLessThan},
                                {29'd0, e.res, e.ovf, e.neq, e.lt});
                    if (e.ovf && next_cnt != 255) next_cnt++;
                end
            end
            if (ovf_clear) next_cnt = 0;
            model_cnt = next_cnt;
        end
    end

    initial begin
        logic [WIDTH-1:0] a, b;
        logic [4:0]       op;
        logic             sat;
        logic [WIDTH-1:0] va[4];
        int               accepted;
        bit               found;

        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ovf_clear = 1'b0;
        data_operandA = '0; data_operandB = '0; ctrl_ALUopcode = '0; sat_en = 1'b0;
        #12;
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_outputs", 64'({data_result, overflow, isNotEqual, isLessThan}), 64'd0);
        checkOutput("reset_ovf_count", 64'(ovf_count), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        out_ready = 1'b1;

        // Cross-half carry, with explicit two-cycle latency check.
        applyStimulus(32'h0000_FFFF, 32'h0000_0001, 5'd0, 1'b0, mkExp(32'h0001_0000, 0, 1, 0), 0);
        @(negedge clock);
        in_valid = 1'b0;
        #1 checkOutput("latency_early", 64'(out_valid), 64'd0);
        @(posedge clock);
        #1 checkOutput("latency_result", 64'({out_valid, data_result}), {31'd0, 1'b1, 32'h0001_0000});

        applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 1'b0, mkExp(32'h8000_0000, 1, 1, 0), 0);
        applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 1'b1, mkExp(32'h7FFF_FFFF, 1, 1, 0), 0);
        drain();
        checkOutput("ovf_count_two", 64'(ovf_count), 64'd2);

        applyStimulus(32'd5, 32'd7, 5'b10101, 1'b0, mkExp(32'hFFFF_FFFE, 0, 1, 1), 0);
        applyStimulus(32'h8000_0000, 32'h0000_0001, 5'd1, 1'b1, mkExp(32'h8000_0000, 1, 1, 1), 0);
        applyStimulus(32'd9, 32'd9, 5'd1, 1'b0, mkExp(32'h0, 0, 0, 0), 0);
        drain();

        // Back-pressure: out_ready low for the first three cycles of a burst.
        for (int i = 0; i < 4; i++) va[i] = $urandom;
        accepted = 0;
        for (int c = 0; c < 20 && accepted < 4; c++) begin
            @(negedge clock);
            out_ready = (c >= 3);
            in_valid = 1'b1;
            data_operandA = va[accepted];
            data_operandB = 32'h1234_5678;
            ctrl_ALUopcode = 5'd1;
            sat_en = 1'b0;
            #1;
            if (c == 2) checkOutput("stall_in_ready", 64'({in_ready, 8'(accepted)}), {55'd0, 1'b0, 8'd2});
            if (in_ready) begin
                exp_q.push_back(refModel(va[accepted], 32'h1234_5678, 5'd1, 1'b0));
                accepted++;
            end
        end
        checkOutput("stall_accepted", 64'(accepted), 64'd4);
        drain();

        // Randomised traffic with random back-pressure.
        for (int i = 0; i < 300; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? a : $urandom;
            if ($urandom_range(0, 9) == 0) a = 32'h7FFF_FFFF;
            if ($urandom_range(0, 9) == 0) b = 32'h8000_0000;
            op = 5'($urandom);
            sat = 1'($urandom);
            applyStimulus(a, b, op, sat, refModel(a, b, op, sat), 1);
        end
        drain();

        // Counter saturation.
        for (int i = 0; i < 300; i++)
            applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 1'b0, mkExp(32'h8000_0000, 1, 1, 0), 0);
        drain();
        checkOutput("ovf_count_sat", 64'(ovf_count), 64'hFF);

        // Clear alone, one increment, then clear coinciding with an overflow transfer.
        @(negedge clock);
        ovf_clear = 1'b1;
        @(negedge clock);
        ovf_clear = 1'b0;
        #1 checkOutput("ovf_clear_idle", 64'(ovf_count), 64'd0);
        applyStimulus(32'h8000_0000, 32'h0000_0001, 5'd1, 1'b0, mkExp(32'h7FFF_FFFF, 1, 1, 1), 0);
        drain();
        checkOutput("ovf_count_one", 64'(ovf_count), 64'd1);
        applyStimulus(32'h8000_0000, 32'h0000_0001, 5'd1, 1'b0, mkExp(32'h7FFF_FFFF, 1, 1, 1), 0);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clock);
            in_valid = 1'b0;
            if (out_valid) begin
                ovf_clear = 1'b1;
                found = 1;
            end
        end
        checkOutput("clear_found_transfer", 64'(found), 64'd1);
        @(negedge clock);
        ovf_clear = 1'b0;
        #1 checkOutput("ovf_clear_priority", 64'(ovf_count), 64'd0);
        drain();

        // Reset with two sets in flight.
        applyStimulus(32'd100, 32'd1, 5'd0, 1'b0, mkExp(32'd101, 0, 1, 0), 0);
        applyStimulus(32'd200, 32'd2, 5'd0, 1'b0, mkExp(32'd202, 0, 1, 0), 0);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midreset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("midreset_result", 64'(data_result), 64'd0);
        @(negedge clock);
        in_valid = 1'b0;
        @(posedge clock);
        #2 reset_n = 1'b1;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            #1 if (out_valid) found = 1;
        end
        checkOutput("no_result_after_reset", 64'(found), 64'd0);

        $display("[TB] %0d tests run, %0d failed", test_count, error_count);
        $finish;
    end

endmodule

// File: doc/add_sub_pipe.md
ADD_SUB_PIPE -- requirements
Module: add_sub_pipe

Interface
REQ-001 Parameter WIDTH, default 32, sets the operand and result width; it SHALL be even and at least 4.
REQ-002 Parameter CNT_W, default 8, sets the width of the overflow event counter.
REQ-003 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  operand set presented.
REQ-006 in_ready  output  1  block accepts an operand set this cycle.
REQ-007 data_operandA, data_operandB  input  WIDTH  signed two's-complement operands.
REQ-008 ctrl_ALUopcode  input  5  bit0: 0 = add, 1 = subtract (A-B); bits 4:1 are ignored.
REQ-009 sat_en  input  1  saturate the result on overflow; sampled with the operands.
REQ-010 out_valid  output  1  result presented.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 data_result  output  WIDTH  sum or difference, saturated when selected.
REQ-013 overflow, isNotEqual, isLessThan  output  1 each  signed-overflow, A!=B and signed A<B flags.
REQ-014 ovf_count  output  CNT_W  count of delivered results with overflow=1.
REQ-015 ovf_clear  input  1  synchronous counter clear.

Function
REQ-016 The datapath SHALL be a two-stage pipeline:
- stage 1 registers the lower WIDTH/2 sum bits and the carry out of that half, together with the upper operand halves, opcode bit0, sat_en, A[msb] and isNotEqual;
- stage 2 completes the upper half and computes the flags.
REQ-017 Subtraction SHALL be formed as A + ~B with a carry-in of 1; addition SHALL use a carry-in of 0.
REQ-018 overflow SHALL be the XOR of the carry into and the carry out of the MSB.
REQ-019 isLessThan SHALL be the raw (unsaturated) result MSB XOR overflow, for both opcodes.
REQ-020 isNotEqual SHALL be 1 iff A differs from B in any bit, for both opcodes.
REQ-021 When sat_en=1 and overflow=1:
- data_result SHALL be the minimum signed value (1 followed by zeros) if A[msb]=1;
- otherwise it SHALL be the maximum signed value (0 followed by ones);
- overflow SHALL still read 1.
REQ-022 Stall logic:
- adv2 = !s2_valid || out_ready;
- adv1 = !s1_valid || adv2;
- in_ready SHALL equal adv1 (combinational).
REQ-023 An operand set SHALL be accepted when in_valid && in_ready; accepted results SHALL appear on out_valid exactly 2 cycles later if out_ready stays high.
REQ-024 While out_valid=1 and out_ready=0, all outputs SHALL hold stable. Stage 1 SHALL still fill if it is empty (bubble collapse).
REQ-025 Results SHALL leave in acceptance order, with no loss or duplication; sustained throughput SHALL be 1 per cycle.
REQ-026 ovf_count SHALL increment by 1 on each transfer (out_valid && out_ready) with overflow=1, and SHALL saturate at all-ones.
REQ-027 ovf_clear=1 SHALL zero ovf_count on the next edge and SHALL take priority over a same-cycle increment.

Reset
REQ-028 reset_n=0 SHALL immediately force:
- both stage valids, out_valid, data_result, overflow, isNotEqual, isLessThan and ovf_count to 0;
- in_ready to 1.
REQ-029 Reset asserted mid-operation SHALL discard in-flight results; no result SHALL emerge after release without a new acceptance.

Verification (WIDTH=32, CNT_W=8)
REQ-030 Add 0x0000FFFF+0x00000001, out_ready=1 -> 2 cycles later 0x00010000, overflow=0, isNotEqual=1 (cross-half carry).
REQ-031 Add 0x7FFFFFFF+0x00000001:
- sat_en=0 -> 0x80000000, overflow=1, ovf_count=1;
- repeated with sat_en=1 -> 0x7FFFFFFF, overflow=1, ovf_count=2.
REQ-032 Subtract cases:
- 5-7 -> 0xFFFFFFFE, isLessThan=1, overflow=0;
- 0x80000000-0x00000001 with sat_en=1 -> 0x80000000, overflow=1, isLessThan=1;
- 9-9 -> 0, isNotEqual=0, isLessThan=0.
REQ-033 Offer 4 back-to-back sets with out_ready=0 for 3 cycles -> in_ready drops after 2 acceptances, outputs stay stable, all 4 results delivered in order once out_ready=1.
REQ-034 Deliver 300 overflowing results -> ovf_count=0xFF. Assert ovf_clear on the same cycle as an overflow transfer -> ovf_count=0.
REQ-035 Pulse reset_n low with 2 sets in flight -> out_valid=0 immediately, in_ready=1, and no result after release.
